// File: rtl/fpu_pkg.sv
// Shared definitions for the float arbiter slice: opcodes, FSM states,
// special encodings and the 16-bit float field layout (1/8/7, bias 127).
package fpu_pkg;

    localparam int WORD_W = 16;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'd0;
    localparam logic [OP_W-1:0] OP_MUL   = 3'd1;
    localparam logic [OP_W-1:0] OP_SLT   = 3'd2;
    localparam logic [OP_W-1:0] OP_RECIP = 3'd3;
    localparam logic [OP_W-1:0] OP_SHIFT = 3'd4;
    localparam logic [OP_W-1:0] OP_I2F   = 3'd5;
    localparam logic [OP_W-1:0] OP_F2I   = 3'd6;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd7;

    localparam logic [WORD_W-1:0] FNAN  = 16'hffc0;
    localparam logic [WORD_W-1:0] INAN  = 16'h8000;
    localparam logic [WORD_W-1:0] FZERO = 16'h0000;
    localparam logic [WORD_W-1:0] FINF  = 16'h7f80;

    localparam int SIGN_BIT = 15;
    localparam int EXP_HI   = 14;
    localparam int EXP_LO   = 7;
    localparam int MAN_HI   = 6;
    localparam int MAN_LO   = 0;
    localparam int EXP_BIAS = 127;

    typedef enum logic [1:0] {IDLE, DIV1, EXEC, RESP} state_t;

    // NaN = all-ones exponent with a non-zero mantissa
    function automatic logic is_nan(input logic [WORD_W-1:0] x);
        return (x[EXP_HI:EXP_LO] == 8'hff) && (x[MAN_HI:MAN_LO] != 7'd0);
    endfunction

endpackage

// File: rtl/fpu_unit.sv
// Combinational float datapath: one op per call, truncating rounding,
// subnormals flushed to zero, overflow saturates to infinity.
module fpu_unit
    import fpu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] res
);

    // Reciprocal mantissa table: frac(2/(1.m)) in 1/128 units; entry 0 is 0
    // because 1/(power of two) is handled exactly with a different exponent.
    logic [6:0] recip_lut [128];
    for (genvar gi = 0; gi < 128; gi++) begin : g_lut
        if (gi == 0) begin : g_zero
            assign recip_lut[gi] = 7'd0;
        end else begin : g_entry
            assign recip_lut[gi] = 7'((32768 / (128 + gi)) - 128);
        end
    end

    function automatic logic [WORD_W-1:0] pack(input logic s, input int e, input logic [6:0] m);
        if (e <= 0)   return {s, 15'd0};
        if (e >= 255) return {s, FINF[EXP_HI:0]};
        return {s, e[7:0], m};
    endfunction

    function automatic logic [WORD_W-1:0] f_add(input logic [WORD_W-1:0] x0, input logic [WORD_W-1:0] y0);
        logic [WORD_W-1:0] x, y;
        logic [11:0] mx, my, sum, norm;
        int ex, ey, d, p;
        if (is_nan(x0) || is_nan(y0)) return FNAN;
        if (x0[EXP_HI:0] >= y0[EXP_HI:0]) begin x = x0; y = y0; end
        else begin x = y0; y = x0; end
        ex = int'(x[EXP_HI:EXP_LO]);
        ey = int'(y[EXP_HI:EXP_LO]);
        if (ex == 255) return x;
        if (ex == 0) return FZERO;
        mx = {2'b01, x[MAN_HI:MAN_LO], 3'b000};
        my = (ey == 0) ? 12'd0 : {2'b01, y[MAN_HI:MAN_LO], 3'b000};
        d  = ex - ey;
        my = (d > 11) ? 12'd0 : (my >> d);
        sum = (x[SIGN_BIT] == y[SIGN_BIT]) ? (mx + my) : (mx - my);
        if (sum == 12'd0) return FZERO;
        if (sum[11]) return pack(x[SIGN_BIT], ex + 1, sum[10:4]);
        p = 0;
        for (int i = 0; i < 11; i++) if (sum[i]) p = i;
        norm = sum << (10 - p);
        return pack(x[SIGN_BIT], ex - (10 - p), norm[9:3]);
    endfunction

    function automatic logic [WORD_W-1:0] f_mul(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y);
        logic [15:0] prod;
        logic s;
        int e;
        if (is_nan(x) || is_nan(y)) return FNAN;
        s = x[SIGN_BIT] ^ y[SIGN_BIT];
        if (x[EXP_HI:EXP_LO] == 8'd0 || y[EXP_HI:EXP_LO] == 8'd0) return {s, 15'd0};
        if (x[EXP_HI:EXP_LO] == 8'hff || y[EXP_HI:EXP_LO] == 8'hff) return {s, FINF[EXP_HI:0]};
        prod = {8'd0, 1'b1, x[MAN_HI:MAN_LO]} * {8'd0, 1'b1, y[MAN_HI:MAN_LO]};
        e = int'(x[EXP_HI:EXP_LO]) + int'(y[EXP_HI:EXP_LO]) - EXP_BIAS;
        if (prod[15]) return pack(s, e + 1, prod[14:8]);
        return pack(s, e, prod[13:7]);
    endfunction

    // Order-preserving key compare; +0 and -0 are equal
    function automatic logic [WORD_W-1:0] f_slt(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y);
        logic [15:0] kx, ky;
        if (is_nan(x) || is_nan(y)) return 16'h0000;
        if (x[EXP_HI:0] == 15'd0 && y[EXP_HI:0] == 15'd0) return 16'h0000;
        kx = x[SIGN_BIT] ? ~x : (x | 16'h8000);
        ky = y[SIGN_BIT] ? ~y : (y | 16'h8000);
        return (kx < ky) ? 16'h0001 : 16'h0000;
    endfunction

    // Scale by 2^b, b a signed integer
    function automatic logic [WORD_W-1:0] f_shift(input logic [WORD_W-1:0] x, input logic [WORD_W-1:0] y);
        if (is_nan(x)) return FNAN;
        if (x[EXP_HI:EXP_LO] == 8'd0) return {x[SIGN_BIT], 15'd0};
        if (x[EXP_HI:EXP_LO] == 8'hff) return x;
        return pack(x[SIGN_BIT], int'(x[EXP_HI:EXP_LO]) + int'($signed(y)), x[MAN_HI:MAN_LO]);
    endfunction

    function automatic logic [WORD_W-1:0] f_i2f(input logic [WORD_W-1:0] x);
        logic [15:0] mag, norm;
        int p;
        mag = x[SIGN_BIT] ? (~x + 16'd1) : x;
        if (mag == 16'd0) return FZERO;
        p = 0;
        for (int i = 0; i < 16; i++) if (mag[i]) p = i;
        norm = mag << (15 - p);
        return pack(x[SIGN_BIT], EXP_BIAS + p, norm[14:8]);
    endfunction

    // Truncates toward zero, saturates out-of-range magnitudes
    function automatic logic [WORD_W-1:0] f_f2i(input logic [WORD_W-1:0] x);
        logic [22:0] wide;
        logic [15:0] mag;
        int sh;
        if (is_nan(x)) return INAN;
        if (int'(x[EXP_HI:EXP_LO]) < EXP_BIAS) return 16'h0000;
        sh = int'(x[EXP_HI:EXP_LO]) - EXP_BIAS;
        if (sh >= 15) return x[SIGN_BIT] ? 16'h8000 : 16'h7fff;
        wide = {15'd0, 1'b1, x[MAN_HI:MAN_LO]} << sh;
        mag  = wide[22:7];
        return x[SIGN_BIT] ? (~mag + 16'd1) : mag;
    endfunction

    logic [WORD_W-1:0] recip_res;

    // Reciprocal: exact for powers of two, table mantissa otherwise
    always_comb begin
        recip_res = FNAN;
        if (!is_nan(a)) begin
            if (a[EXP_HI:EXP_LO] == 8'd0)
                recip_res = {a[SIGN_BIT], FINF[EXP_HI:0]};
            else if (a[EXP_HI:EXP_LO] == 8'hff)
                recip_res = {a[SIGN_BIT], 15'd0};
            else if (a[MAN_HI:MAN_LO] == 7'd0)
                recip_res = pack(a[SIGN_BIT], 2 * EXP_BIAS - int'(a[EXP_HI:EXP_LO]), 7'd0);
            else
                recip_res = pack(a[SIGN_BIT], 2 * EXP_BIAS - 1 - int'(a[EXP_HI:EXP_LO]),
                                 recip_lut[a[MAN_HI:MAN_LO]]);
        end
    end

    // Result select; divide never reaches here as a single op
    always_comb begin
        res = FNAN;
        case (op)
            OP_ADD:   res = f_add(a, b);
            OP_MUL:   res = f_mul(a, b);
            OP_SLT:   res = f_slt(a, b);
            OP_RECIP: res = recip_res;
            OP_SHIFT: res = f_shift(a, b);
            OP_I2F:   res = f_i2f(a);
            OP_F2I:   res = f_f2i(a);
            default:  res = FNAN;
        endcase
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one fpu_unit between NREQ requesters;
// divide runs as recip(b) followed by a*recip(b) through the same unit.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ = 2
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [OP_W*NREQ-1:0]     req_op,
    input  logic [WORD_W*NREQ-1:0]   req_a,
    input  logic [WORD_W*NREQ-1:0]   req_b,
    output logic                     rsp_valid,
    output logic [1:0]               rsp_id,
    output logic [WORD_W-1:0]        rsp_data,
    output logic                     busy
);

    state_t              state;
    logic [1:0]          rr;
    logic [OP_W-1:0]     op_r;
    logic [WORD_W-1:0]   a_r, b_r, res_r;
    logic [1:0]          id_r;
    logic                run;        // holds ready low until the first edge after reset

    logic [OP_W-1:0]     op_arr [NREQ];
    logic [WORD_W-1:0]   a_arr  [NREQ];
    logic [WORD_W-1:0]   b_arr  [NREQ];
    logic [1:0]          grant;
    logic                found, hs;
    logic [OP_W-1:0]     sel_op, u_op;
    logic [WORD_W-1:0]   sel_a, sel_b, u_a, unit_res;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
        assign op_arr[gi] = req_op[OP_W*gi +: OP_W];
        assign a_arr[gi]  = req_a[WORD_W*gi +: WORD_W];
        assign b_arr[gi]  = req_b[WORD_W*gi +: WORD_W];
    end

    // First valid requester scanning from rr upwards, wrapping at NREQ
    always_comb begin
        grant = 2'd0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++)
            for (int j = 0; j < NREQ; j++)
                if (!found && j == (int'(rr) + k) % NREQ && req_valid[j]) begin
                    found = 1'b1;
                    grant = 2'(j);
                end
    end

    assign hs = run && found && (state == IDLE || state == RESP);

    // One-hot ready for the winner, operand mux for the latch
    always_comb begin
        req_ready = '0;
        sel_op    = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int j = 0; j < NREQ; j++)
            if (grant == 2'(j)) begin
                req_ready[j] = hs;
                sel_op       = op_arr[j];
                sel_a        = a_arr[j];
                sel_b        = b_arr[j];
            end
    end

    // DIV1 borrows the unit to turn b into 1/b
    assign u_op = (state == DIV1) ? OP_RECIP : op_r;
    assign u_a  = (state == DIV1) ? b_r : a_r;

    fpu_unit u_unit (
        .op  (u_op),
        .a   (u_a),
        .b   (b_r),
        .res (unit_res)
    );

    // Sequencer: accept in IDLE/RESP, optional recip pass, execute, respond
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rr    <= 2'd0;
            op_r  <= '0;
            a_r   <= '0;
            b_r   <= '0;
            id_r  <= 2'd0;
            res_r <= '0;
            run   <= 1'b0;
        end else begin
            run <= 1'b1;
            case (state)
                IDLE, RESP: begin
                    if (hs) begin
                        op_r  <= sel_op;
                        a_r   <= sel_a;
                        b_r   <= sel_b;
                        id_r  <= grant;
                        rr    <= 2'((int'(grant) + 1) % NREQ);
                        state <= (sel_op == OP_DIV) ? DIV1 : EXEC;
                    end else begin
                        state <= IDLE;
                    end
                end
                DIV1: begin
                    b_r   <= unit_res;
                    op_r  <= OP_MUL;
                    state <= EXEC;
                end
                EXEC: begin
                    res_r <= unit_res;
                    state <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state == RESP);
    assign rsp_id    = id_r;
    assign rsp_data  = res_r;
    assign busy      = (state != IDLE);

endmodule
